caja_fuerte_secuencial: RTL and testbench
=========================================

# caja_fuerte_secuencial

Sequential keypad-entry side of the safe lock. It accepts one 4-bit digit per `key_valid` pulse, assembles a fixed-length combination, and compares it against a parameterised code. It then drives the open output for a bounded time, or counts failures and enters a timed lockout with alarm. It sits between the keypad scanner and the bolt/alarm drivers.

## Interface
- `CODE`, 16'h1234, stored combination; first digit entered occupies bits [15:12].
- `N_DIGITS`, 4, digits per attempt (fixed at 4; `CODE` width = 4*N_DIGITS).
- `MAX_FAIL`, 3, consecutive failures before lockout (legal 1..3).
- `OPEN_CYCLES`, 8, cycles `abierta` stays high (≥1).
- `LOCKOUT_CYCLES`, 16, cycles of lockout (≥1).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `key_valid` in 1: one-cycle strobe, `key` valid.
- `key` in 4: digit value 0..15.
- `clear` in 1: abort current entry.
- `cerrar` in 1: close an open safe early.
- `abierta` out 1: safe open.
- `alarma` out 1: lockout active.
- `ocupado` out 1: keys currently ignored (CHECK, OPEN, LOCKOUT).
- `fallos` out 2: consecutive failure count.
- `digitos` out 3: digits collected in current attempt.

## Operation
- States: IDLE, ENTRY, CHECK, OPEN, LOCKOUT. Shared down-timer sized $clog2(max(OPEN_CYCLES,LOCKOUT_CYCLES)+1).
- IDLE: `key_valid` → shift `key` into buffer, `digitos`=1, go ENTRY.
- ENTRY: each `key_valid` shifts buffer left 4 and increments `digitos`. On the N_DIGITS-th key go CHECK.
- ENTRY with `clear`: buffer and `digitos` zeroed, go IDLE. `fallos` unchanged. `clear` beats `key_valid` in the same cycle. `clear` ignored in all other states.
- CHECK (exactly one cycle): buffer==CODE → OPEN, `fallos`←0, timer←OPEN_CYCLES-1. Otherwise `fallos`+1. If the new value equals MAX_FAIL → LOCKOUT, timer←LOCKOUT_CYCLES-1; else → IDLE. `digitos`←0 on leaving CHECK.
- OPEN: `abierta`=1. Timer decrements each cycle; at timer==0 or `cerrar`=1 → IDLE.
- LOCKOUT: `alarma`=1. Timer decrements; at timer==0 → IDLE with `fallos`←0. `cerrar` ignored.
- `key_valid` in CHECK/OPEN/LOCKOUT is dropped, not queued.
- Outputs are decoded from registered state/counters only, with no combinational path from inputs.

## Timing
- Reset values: state IDLE, buffer 0, timer 0, `abierta` 0, `alarma` 0, `ocupado` 0, `fallos` 0, `digitos` 0. Reset is asynchronous: asserting `rst` mid-entry, mid-open or mid-lockout clears all outputs immediately, without waiting for a clock edge.
- Final digit sampled at edge N → CHECK after N → `abierta` (or `alarma`) high after edge N+1. Latency: 2 edges.
- `abierta` high for exactly OPEN_CYCLES cycles. With `cerrar` sampled at edge M, `abierta` is low after M.
- `alarma` high for exactly LOCKOUT_CYCLES cycles, then `fallos` reads 0 in the same cycle `alarma` drops.
- Back-to-back `key_valid` on consecutive cycles is legal in IDLE/ENTRY.
- A `key_valid` in the first IDLE cycle after OPEN/LOCKOUT/ENTRY-abort is accepted.

## Structure
- `caja_fuerte_pkg`: state enum, `DIGIT_W`=4, `FALLOS_W`=2.
- Sub-module `temporizador`: loadable down-counter with load, enable and zero flag; parameterised width. Shared by OPEN and LOCKOUT.

## Test plan
- Default params; reset, keys 1,2,3,4 on consecutive cycles → `abierta` high 2 edges after key 4 for exactly 8 cycles; `fallos`=0 throughout.
- Keys 1,2,3,5 three times → `fallos` 1, 2, then `alarma` high 16 cycles with `ocupado`=1. Keys 1,2,3,4 during lockout ignored and `digitos` stays 0. `fallos`=0 after.
- Keys 1,2 then `clear` → `digitos`=0 and state IDLE. Then 1,2,3,4 → opens; `fallos` never incremented.
- Open, `cerrar` on 3rd open cycle → `abierta` low next cycle; `cerrar` in IDLE has no effect.
- One failure, then correct code → `fallos` goes 1→0 at CHECK. `rst` pulse mid-LOCKOUT (between edges) → `alarma`, `ocupado` fall before next edge.
- `clear` and `key_valid`(key=7) same cycle in ENTRY → digit discarded, `digitos`=0. `key_valid` during CHECK → dropped, no effect on next attempt.

Source files
------------

// File: rtl/caja_fuerte_secuencial_pkg.sv
// Shared types and widths for the sequential safe-lock keypad block.
package caja_fuerte_pkg;

   localparam int DIGIT_W   = 4;
   localparam int FALLOS_W  = 2;
   localparam int DIGITOS_W = 3;

   typedef enum logic [2:0] {
      IDLE,
      ENTRY,
      CHECK,
      OPEN,
      LOCKOUT
   } estado_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/caja_fuerte_secuencial_if.sv
// Keypad-side inputs and bolt/alarm-side status outputs of the safe lock.
interface caja_fuerte_secuencial_if;
   import caja_fuerte_pkg::*;

   logic                 key_valid;
   logic [DIGIT_W-1:0]   key;
   logic                 clear;
   logic                 cerrar;
   logic                 abierta;
   logic                 alarma;
   logic                 ocupado;
   logic [FALLOS_W-1:0]  fallos;
   logic [DIGITOS_W-1:0] digitos;

   modport master (
      output key_valid, key, clear, cerrar,
      input  abierta, alarma, ocupado, fallos, digitos
   );

   modport slave (
      input  key_valid, key, clear, cerrar,
      output abierta, alarma, ocupado, fallos, digitos
   );

endinterface

// File: rtl/caja_fuerte_secuencial_temporizador.sv
// Loadable down-counter shared by the open window and the lockout period.
module temporizador #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         enable,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/caja_fuerte_secuencial.sv
// Keypad combination lock: collects digits, checks the code, opens for a
// bounded time or counts failures into a timed alarm lockout.
module caja_fuerte_secuencial
   import caja_fuerte_pkg::*;
#(
   parameter int                          N_DIGITS       = 4,
   parameter logic [DIGIT_W*N_DIGITS-1:0] CODE           = 16'h1234,
   parameter int                          MAX_FAIL       = 3,
   parameter int                          OPEN_CYCLES    = 8,
   parameter int                          LOCKOUT_CYCLES = 16
) (
   input logic                     clk,
   input logic                     rst,
   caja_fuerte_secuencial_if.slave bus
);

   localparam int CODE_W  = DIGIT_W * N_DIGITS;
   localparam int TIMER_W = $clog2(max_int(OPEN_CYCLES, LOCKOUT_CYCLES) + 1);

   localparam logic [TIMER_W-1:0]   OPEN_LOAD  = TIMER_W'(OPEN_CYCLES - 1);
   localparam logic [TIMER_W-1:0]   LOCK_LOAD  = TIMER_W'(LOCKOUT_CYCLES - 1);
   localparam logic [FALLOS_W-1:0]  FAIL_LIMIT = FALLOS_W'(MAX_FAIL);
   localparam logic [DIGITOS_W-1:0] LAST_KEY   = DIGITOS_W'(N_DIGITS - 1);

   estado_t              state, state_next;
   logic [CODE_W-1:0]    buffer, buffer_next;
   logic [DIGITOS_W-1:0] digitos, digitos_next;
   logic [FALLOS_W-1:0]  fallos, fallos_next, fallos_inc;
   logic                 timer_load, timer_enable, timer_zero;
   logic [TIMER_W-1:0]   timer_value;

   temporizador #(
      .W (TIMER_W)
   ) u_temporizador (
      .clk        (clk),
      .rst        (rst),
      .load       (timer_load),
      .load_value (timer_value),
      .enable     (timer_enable),
      .zero       (timer_zero)
   );

   assign fallos_inc = fallos + FALLOS_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         buffer  <= '0;
         digitos <= '0;
         fallos  <= '0;
      end else begin
         state   <= state_next;
         buffer  <= buffer_next;
         digitos <= digitos_next;
         fallos  <= fallos_next;
      end
   end

   always_comb begin
      state_next   = state;
      buffer_next  = buffer;
      digitos_next = digitos;
      fallos_next  = fallos;
      timer_load   = 1'b0;
      timer_value  = OPEN_LOAD;
      timer_enable = 1'b0;

      case (state)
         IDLE: begin
            if (bus.key_valid) begin
               buffer_next  = CODE_W'(bus.key);
               digitos_next = DIGITOS_W'(1);
               state_next   = ENTRY;
            end
         end

         ENTRY: begin
            // An abort wins over a digit arriving in the same cycle.
            if (bus.clear) begin
               buffer_next  = '0;
               digitos_next = '0;
               state_next   = IDLE;
            end else if (bus.key_valid) begin
               buffer_next  = {buffer[CODE_W-DIGIT_W-1:0], bus.key};
               digitos_next = digitos + DIGITOS_W'(1);
               if (digitos == LAST_KEY) begin
                  state_next = CHECK;
               end
            end
         end

         CHECK: begin
            digitos_next = '0;
            if (buffer == CODE) begin
               fallos_next = '0;
               timer_load  = 1'b1;
               timer_value = OPEN_LOAD;
               state_next  = OPEN;
            end else begin
               fallos_next = fallos_inc;
               if (fallos_inc == FAIL_LIMIT) begin
                  timer_load  = 1'b1;
                  timer_value = LOCK_LOAD;
                  state_next  = LOCKOUT;
               end else begin
                  state_next = IDLE;
               end
            end
         end

         OPEN: begin
            timer_enable = 1'b1;
            if (timer_zero || bus.cerrar) begin
               state_next = IDLE;
            end
         end

         LOCKOUT: begin
            timer_enable = 1'b1;
            if (timer_zero) begin
               fallos_next = '0;
               state_next  = IDLE;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   assign bus.abierta = (state == OPEN);
   assign bus.alarma  = (state == LOCKOUT);
   assign bus.ocupado = (state == CHECK) || (state == OPEN) || (state == LOCKOUT);
   assign bus.fallos  = fallos;
   assign bus.digitos = digitos;

endmodule

// File: tb/tb_caja_fuerte_secuencial.sv
// Scoreboard bench for caja_fuerte_secuencial: stimulus queues expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_caja_fuerte_secuencial;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   caja_fuerte_secuencial_if bus ();

   caja_fuerte_secuencial dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Packed view: {abierta, alarma, ocupado, fallos[1:0], digitos[2:0]}
   typedef struct {
      int         cyc;
      string      name;
      logic [7:0] val;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   cyc = 0;
   int   checks_total = 0;
   int   checks_pass = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         mon_e = exp_q.pop_front();
         checks_total++;
         if (mon_e.cyc < cyc) begin
            $display("FAIL %s: not sampled at cycle %0d (now %0d), required %b",
                     mon_e.name, mon_e.cyc, cyc, mon_e.val);
         end else if ({bus.abierta, bus.alarma, bus.ocupado, bus.fallos, bus.digitos} === mon_e.val) begin
            checks_pass++;
         end else begin
            $display("FAIL %s: cycle %0d got ab/al/oc/fa/di=%b required %b", mon_e.name, cyc,
                     {bus.abierta, bus.alarma, bus.ocupado, bus.fallos, bus.digitos}, mon_e.val);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed",
               checks_pass, checks_total);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_now(input string n, input logic ab, input logic al, input logic oc,
                             input logic [1:0] fa, input logic [2:0] di);
      exp_t e;
      e.cyc  = cyc;
      e.name = n;
      e.val  = {ab, al, oc, fa, di};
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic kv, input logic [3:0] k, input logic clr, input logic cer);
      bus.key_valid = kv;
      bus.key       = k;
      bus.clear     = clr;
      bus.cerrar    = cer;
      tick();
      bus.key_valid = 1'b0;
      bus.key       = 4'h0;
      bus.clear     = 1'b0;
      bus.cerrar    = 1'b0;
   endtask

   // Four digits from IDLE; ends in the CHECK cycle.
   task automatic enter(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                        input logic [3:0] d3, input logic [1:0] fa);
      drive(1'b1, d0, 1'b0, 1'b0);
      expect_now("entry_d1", 1'b0, 1'b0, 1'b0, fa, 3'd1);
      drive(1'b1, d1, 1'b0, 1'b0);
      expect_now("entry_d2", 1'b0, 1'b0, 1'b0, fa, 3'd2);
      drive(1'b1, d2, 1'b0, 1'b0);
      expect_now("entry_d3", 1'b0, 1'b0, 1'b0, fa, 3'd3);
      drive(1'b1, d3, 1'b0, 1'b0);
      expect_now("check", 1'b0, 1'b0, 1'b1, fa, 3'd4);
   endtask

   initial begin
      bus.key_valid = 1'b0;
      bus.key       = 4'h0;
      bus.clear     = 1'b0;
      bus.cerrar    = 1'b0;

      tick();
      expect_now("reset", 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
      tick();
      rst = 1'b0;
      tick();
      expect_now("after_reset", 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);

      // Correct code, full open window
      enter(4'd1, 4'd2, 4'd3, 4'd4, 2'd0);
      tick();
      expect_now("open_c1", 1'b1, 1'b0, 1'b1, 2'd0, 3'd0);
      for (int i = 2; i <= 8; i++) begin
         tick();
         expect_now("open_window", 1'b1, 1'b0, 1'b1, 2'd0, 3'd0);
      end
      tick();
      expect_now("open_end", 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);

      // Three wrong attempts into lockout; keys during lockout dropped
      enter(4'd1, 4'd2, 4'd3, 4'd5, 2'd0);
      tick();
      expect_now("fail1", 1'b0, 1'b0, 1'b0, 2'd1, 3'd0);
      enter(4'd1, 4'd2, 4'd3, 4'd5, 2'd1);
      tick();
      expect_now("fail2", 1'b0, 1'b0, 1'b0, 2'd2, 3'd0);
      enter(4'd1, 4'd2, 4'd3, 4'd5, 2'd2);
      tick();
      expect_now("lock_c1", 1'b0, 1'b1, 1'b1, 2'd3, 3'd0);
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 4'(i), 1'b0, 1'b0);
         expect_now("lock_keys_ignored", 1'b0, 1'b1, 1'b1, 2'd3, 3'd0);
      end
      for (int i = 6; i <= 16; i++) begin
         tick();
         expect_now("lock_window", 1'b0, 1'b1, 1'b1, 2'd3, 3'd0);
      end
      tick();
      expect_now("lock_end", 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);

      // Abort with clear, then open and close early
      drive(1'b1, 4'd1, 1'b0, 1'b0);
      expect_now("pre_clear_d1", 1'b0, 1'b0, 1'b0, 2'd0, 3'd1);
      drive(1'b1, 4'd2, 1'b0, 1'b0);
      expect_now("pre_clear_d2", 1'b0, 1'b0, 1'b0, 2'd0, 3'd2);
      drive(1'b0, 4'd0, 1'b1, 1'b0);
      expect_now("clear", 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
      enter(4'd1, 4'd2, 4'd3, 4'd4, 2'd0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         expect_now("open_before_cerrar", 1'b1, 1'b0, 1'b1, 2'd0, 3'd0);
      end
      drive(1'b0, 4'd0, 1'b0, 1'b1);
      expect_now("cerrar", 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
      drive(1'b0, 4'd0, 1'b0, 1'b1);
      expect_now("cerrar_idle", 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);

      // clear beats key_valid; key during CHECK dropped
      drive(1'b1, 4'd1, 1'b0, 1'b0);
      expect_now("pre_tie_d1", 1'b0, 1'b0, 1'b0, 2'd0, 3'd1);
      drive(1'b1, 4'd7, 1'b1, 1'b0);
      expect_now("clear_beats_key", 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
      enter(4'd1, 4'd2, 4'd3, 4'd5, 2'd0);
      drive(1'b1, 4'd1, 1'b0, 1'b0);
      expect_now("key_in_check_dropped", 1'b0, 1'b0, 1'b0, 2'd1, 3'd0);
      enter(4'd1, 4'd2, 4'd3, 4'd4, 2'd1);
      tick();
      expect_now("fail_then_open", 1'b1, 1'b0, 1'b1, 2'd0, 3'd0);
      drive(1'b0, 4'd0, 1'b0, 1'b1);
      expect_now("close_again", 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);

      // Asynchronous reset in the middle of a lockout
      enter(4'd9, 4'd9, 4'd9, 4'd9, 2'd0);
      tick();
      enter(4'd9, 4'd9, 4'd9, 4'd9, 2'd1);
      tick();
      enter(4'd9, 4'd9, 4'd9, 4'd9, 2'd2);
      tick();
      expect_now("lock_before_rst", 1'b0, 1'b1, 1'b1, 2'd3, 3'd0);
      tick();
      rst = 1'b1;
      expect_now("rst_async", 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
      tick();
      rst = 1'b0;
      expect_now("rst_held", 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
      enter(4'd1, 4'd2, 4'd3, 4'd4, 2'd0);
      tick();
      expect_now("open_after_rst", 1'b1, 1'b0, 1'b1, 2'd0, 3'd0);

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) tick();
      while (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         checks_total++;
         $display("FAIL %s: never sampled, required %b", mon_e.name, mon_e.val);
      end

      $display("%0d/%0d checks passed", checks_pass, checks_total);
      $finish;
   end

endmodule
